// File: rtl/vga_frame_monitor_pkg.sv
// Shared types and constants for the VGA frame monitor: FSM state, default
// geometry and the CRC-32 step used when FRAME_MON_CRC_EN is defined.
package vga_mon_pkg;

   typedef enum logic [0:0] {WAIT_VS, IN_FRAME} mon_state_e;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;

   localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   // Advance a non-reflected CRC-32 by one 24-bit pixel, MSB (R[7]) first.
   function automatic logic [31:0] crc32_step24(input logic [31:0] crc, input logic [23:0] data);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 23; i >= 0; i--) begin
         fb = c[31] ^ data[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// VGA pin bundle as driven from the GPU to the DAC. The GPU side is the
// master; the frame monitor only observes it through the slave modport.
interface vga_frame_monitor_if;

   logic       VGA_CLK;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;

   modport master (
      output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
   );

   modport slave (
      input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
   );

endinterface

// File: rtl/vga_frame_monitor_checksum.sv
// Running per-frame checksum. value_o already includes the pixel presented
// in the current cycle, so a frame can be closed on the same cycle as its
// last pixel. Macro FRAME_MON_CRC_EN selects CRC-32 instead of a 32-bit sum.
module frame_checksum
   import vga_mon_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [23:0] pix_i,
   output logic [31:0] value_o
);

   logic [31:0] acc_q, acc_d, acc_upd;

`ifdef FRAME_MON_CRC_EN
   localparam logic [31:0] AccInit = CRC32_INIT;

   // One pixel per enabled cycle through the 24-bit CRC step.
   always_comb acc_upd = crc32_step24(acc_q, pix_i);
`else
   localparam logic [31:0] AccInit = 32'h0000_0000;

   // Modular sum of the zero-extended pixel.
   always_comb acc_upd = acc_q + {8'h00, pix_i};
`endif

   // Clear wins over accumulate for the stored value; value_o still carries
   // the pixel so the closing frame sees it.
   always_comb begin
      value_o = en_i ? acc_upd : acc_q;
      acc_d   = clr_i ? AccInit : value_o;
   end

   // Accumulator register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) acc_q <= AccInit;
      else         acc_q <= acc_d;
   end

endmodule

// File: rtl/vga_frame_monitor.sv
// Passive VGA frame monitor. Samples the GPU pin bundle on CLOCK_50, recovers
// per-line pixel counts and per-frame line counts, flags geometry errors and
// reports a per-frame checksum. Optional macro: FRAME_MON_CRC_EN (CRC-32
// checksum instead of additive sum, handled inside frame_checksum).
module vga_frame_monitor
   import vga_mon_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned CNT_W    = 12
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET_N,
   vga_frame_monitor_if.slave   vga,
   output logic                 pix_valid,
   output logic [CNT_W-1:0]     pix_x,
   output logic [CNT_W-1:0]     pix_y,
   output logic                 frame_done,
   output logic [31:0]          frame_sum,
   output logic [CNT_W-1:0]     frame_lines,
   output logic [15:0]          frame_count,
   output logic                 err_geometry
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] HExp   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] VExp   = CNT_W'(V_ACTIVE);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CntMax) ? v : v + 1'b1;
   endfunction

   // Two-stage input alignment; pixel data is taken from the first stage.
   logic        vclk_q, vclk_qq, vs_q, vs_qq, hs_q, blank_q;
   logic [23:0] rgb_q;

   // Input sampling pipeline.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         vclk_q  <= 1'b0;
         vclk_qq <= 1'b0;
         vs_q    <= 1'b0;
         vs_qq   <= 1'b0;
         hs_q    <= 1'b0;
         blank_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         vclk_q  <= vga.VGA_CLK;
         vclk_qq <= vclk_q;
         vs_q    <= vga.VGA_VS;
         vs_qq   <= vs_q;
         hs_q    <= vga.VGA_HS;
         blank_q <= vga.VGA_BLANK_N;
         rgb_q   <= {vga.VGA_R, vga.VGA_G, vga.VGA_B};
      end
   end

   logic pix_sample, vs_edge;
   assign pix_sample = vclk_q & ~vclk_qq;
   assign vs_edge    = ~vs_q & vs_qq;

   mon_state_e       state_q, state_d;
   logic [CNT_W-1:0] x_q, x_d, line_q, line_d;
   logic             run_q, run_d;      // previous sample was active
   logic             err_q, err_d;
   logic             pix_valid_q, pix_valid_d;
   logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic             frame_done_q, frame_done_d;
   logic [31:0]      frame_sum_q, frame_sum_d;
   logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
   logic [15:0]      frame_count_q, frame_count_d;
   logic             sum_clr, sum_en;
   logic [31:0]      sum_value;

   frame_checksum u_checksum (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .clr_i   (sum_clr),
      .en_i    (sum_en),
      .pix_i   (rgb_q),
      .value_o (sum_value)
   );

   // Next-state: pixel/line tracking, then frame close on a VS edge, which
   // sees the effect of a pixel or line end sampled in the same cycle.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      line_d        = line_q;
      run_d         = run_q;
      err_d         = err_q;
      pix_valid_d   = 1'b0;
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      frame_done_d  = 1'b0;
      frame_sum_d   = frame_sum_q;
      frame_lines_d = frame_lines_q;
      frame_count_d = frame_count_q;
      sum_clr       = 1'b0;
      sum_en        = 1'b0;
      unique case (state_q)
         WAIT_VS: begin
            if (vs_edge) begin
               state_d = IN_FRAME;
               x_d     = '0;
               line_d  = '0;
               run_d   = 1'b0;
               sum_clr = 1'b1;
            end
         end
         IN_FRAME: begin
            if (pix_sample) begin
               if (blank_q) begin
                  pix_valid_d = 1'b1;
                  pix_x_d     = x_q;
                  pix_y_d     = line_q;
                  x_d         = sat_inc(x_q);
                  sum_en      = 1'b1;
                  if (!hs_q) err_d = 1'b1;
               end else if (run_q) begin
                  if (x_q != HExp) err_d = 1'b1;
                  line_d = sat_inc(line_q);
                  x_d    = '0;
               end
               run_d = blank_q;
            end
            if (vs_edge) begin
               // A run still open at VS counts as a finished line.
               if (run_d) begin
                  if (x_d != HExp) err_d = 1'b1;
                  line_d = sat_inc(line_d);
               end
               if (line_d != VExp) err_d = 1'b1;
               frame_lines_d = line_d;
               frame_sum_d   = sum_value;
               frame_count_d = frame_count_q + 16'd1;
               frame_done_d  = 1'b1;
               x_d           = '0;
               line_d        = '0;
               run_d         = 1'b0;
               sum_clr       = 1'b1;
            end
         end
         default: state_d = WAIT_VS;
      endcase
   end

   // Monitor state and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= WAIT_VS;
         x_q           <= '0;
         line_q        <= '0;
         run_q         <= 1'b0;
         err_q         <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_done_q  <= 1'b0;
         frame_sum_q   <= '0;
         frame_lines_q <= '0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         line_q        <= line_d;
         run_q         <= run_d;
         err_q         <= err_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_done_q  <= frame_done_d;
         frame_sum_q   <= frame_sum_d;
         frame_lines_q <= frame_lines_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign pix_valid    = pix_valid_q;
   assign pix_x        = pix_x_q;
   assign pix_y        = pix_y_q;
   assign frame_done   = frame_done_q;
   assign frame_sum    = frame_sum_q;
   assign frame_lines  = frame_lines_q;
   assign frame_count  = frame_count_q;
   assign err_geometry = err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Self-checking bench for vga_frame_monitor on a reduced 16x8 geometry.
// Frames are described as lists of line lengths; a frame-level model gives
// the expected pixel stream, checksum, line count, frame count and error.
module tb_vga_frame_monitor;

   localparam int unsigned HA = 16;
   localparam int unsigned VA = 8;
   localparam int unsigned CW = 12;

`ifdef FRAME_MON_CRC_EN
   localparam logic [31:0] M_INIT = 32'hFFFFFFFF;
`else
   localparam logic [31:0] M_INIT = 32'h0000_0000;
`endif

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic [31:0] cyc;
   } pix_t;

   typedef struct packed {
      logic [31:0] sum;
      logic [11:0] lines;
      logic [15:0] count;
      logic [31:0] cyc;
   } frm_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   vga_frame_monitor_if vga ();

   logic          pix_valid, frame_done, err_geometry;
   logic [CW-1:0] pix_x, pix_y, frame_lines;
   logic [31:0]   frame_sum;
   logic [15:0]   frame_count;

   vga_frame_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CNT_W(CW)) dut (
      .CLOCK_50     (clk),
      .RESET_N      (rst_n),
      .vga          (vga),
      .pix_valid    (pix_valid),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .frame_done   (frame_done),
      .frame_sum    (frame_sum),
      .frame_lines  (frame_lines),
      .frame_count  (frame_count),
      .err_geometry (err_geometry)
   );

   always #10 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] cyc = 0;
   logic [31:0] rise_cyc;

   // Model state
   bit          armed;
   logic [31:0] m_sum;
   int          m_lines;
   bit          m_bad;
   bit          exp_err;
   logic [15:0] exp_count;
   frm_t        exp_f;
   logic [23:0] fixed_rgb;
   pix_t        exp_pix[$];
   pix_t        obs_pix[$];
   frm_t        obs_frm[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pix_valid) obs_pix.push_back('{x: pix_x, y: pix_y, cyc: cyc});
      if (frame_done) obs_frm.push_back('{sum: frame_sum, lines: frame_lines,
                                          count: frame_count, cyc: cyc});
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] model_step(input logic [31:0] acc, input logic [23:0] rgb);
`ifdef FRAME_MON_CRC_EN
      logic [31:0] r;
      r = acc;
      for (int i = 23; i >= 0; i--) r = (r[31] ^ rgb[i]) ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
      return r;
`else
      return acc + {8'h00, rgb};
`endif
   endfunction

   task automatic set_pins(input logic blank, input logic hs, input logic vs, input logic [23:0] rgb);
      vga.VGA_BLANK_N = blank;
      vga.VGA_HS      = hs;
      vga.VGA_VS      = vs;
      {vga.VGA_R, vga.VGA_G, vga.VGA_B} = rgb;
   endtask

   // One pixel period: two CLOCK_50 cycles, data changes with VGA_CLK low.
   task automatic drive_pix(input logic blank, input logic hs, input logic vs, input logic [23:0] rgb);
      @(posedge clk); #1;
      vga.VGA_CLK = 1'b0;
      set_pins(blank, hs, vs, rgb);
      @(posedge clk); #1;
      vga.VGA_CLK = 1'b1;
      rise_cyc = cyc;
   endtask

   task automatic model_clear();
      armed = 0; m_sum = M_INIT; m_lines = 0; m_bad = 0; exp_err = 0; exp_count = 0;
   endtask

   task automatic flush();
      exp_pix.delete(); obs_pix.delete(); obs_frm.delete();
   endtask

   // n lines of HA active pixels each (line short_idx gets short_len), each
   // followed by 4 blank pixels with HS low on the middle two.
   task automatic send_body(input int n, input int short_idx, input int short_len, input bit rnd);
      int          len;
      logic [23:0] rgb;
      for (int l = 0; l < n; l++) begin
         len = (l == short_idx) ? short_len : int'(HA);
         for (int i = 0; i < len; i++) begin
            rgb = rnd ? 24'($urandom) : fixed_rgb;
            drive_pix(1'b1, 1'b1, 1'b1, rgb);
            if (armed) exp_pix.push_back('{x: 12'(i), y: 12'(m_lines), cyc: rise_cyc + 2});
            m_sum = model_step(m_sum, rgb);
         end
         if (len != int'(HA)) m_bad = 1;
         m_lines++;
         for (int b = 0; b < 4; b++) drive_pix(1'b0, (b == 1 || b == 2) ? 1'b0 : 1'b1, 1'b1, 24'h0);
      end
   endtask

   // VS pulse (2 pixels) plus back porch; optionally a lone active pixel
   // sampled in the very cycle VS is first seen low.
   task automatic close_frame(input bit coincident, input logic [23:0] rgb);
      logic [31:0] vs_cyc;
      @(posedge clk); #1;
      vga.VGA_CLK = 1'b0;
      if (coincident) begin
         set_pins(1'b1, 1'b1, 1'b1, rgb);
         @(posedge clk); #1;
         vga.VGA_CLK = 1'b1;
         vga.VGA_VS  = 1'b0;
         vs_cyc = cyc;
         if (armed) exp_pix.push_back('{x: 12'd0, y: 12'(m_lines), cyc: cyc + 2});
         m_sum = model_step(m_sum, rgb);
         if (HA != 1) m_bad = 1;
         m_lines++;
      end else begin
         set_pins(1'b0, 1'b1, 1'b0, 24'h0);
         vs_cyc = cyc;
         @(posedge clk); #1;
         vga.VGA_CLK = 1'b1;
      end
      drive_pix(1'b0, 1'b1, 1'b0, 24'h0);
      drive_pix(1'b0, 1'b1, 1'b1, 24'h0);
      drive_pix(1'b0, 1'b1, 1'b1, 24'h0);
      if (armed) begin
         if (m_lines != int'(VA)) m_bad = 1;
         exp_err   = exp_err | m_bad;
         exp_count = exp_count + 16'd1;
         exp_f     = '{sum: m_sum, lines: 12'(m_lines), count: exp_count, cyc: vs_cyc + 2};
      end
      armed = 1; m_sum = M_INIT; m_lines = 0; m_bad = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pix_valid, frame_done, err_geometry} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 000", {pix_valid, frame_done, err_geometry});
      end
      checks++;
      if (frame_sum !== 32'h0) begin
         errors++; $display("FAIL reset_sum: got %h want 0", frame_sum);
      end
      checks++;
      if ({frame_lines, frame_count, pix_x, pix_y} !== '0) begin
         errors++;
         $display("FAIL reset_counts: lines=%0d count=%0d x=%0d y=%0d want 0",
                  frame_lines, frame_count, pix_x, pix_y);
      end
      #4 rst_n = 1'b1;
      model_clear();
      flush();
      send_body(2, -1, 0, 1);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 0) begin
         errors++; $display("FAIL first_vs_no_done: got %0d frames want 0", obs_frm.size());
      end
   endtask

   task automatic test_standard_frame();
      frm_t f;
      int   bad;
      flush();
      fixed_rgb = 24'h010203;
      send_body(VA, -1, 0, 0);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 1) begin
         errors++; $display("FAIL std_done: got %0d frames want 1", obs_frm.size());
      end else begin
         f = obs_frm.pop_front();
         checks++;
         if (f.sum !== exp_f.sum) begin
            errors++; $display("FAIL std_sum: got %h want %h", f.sum, exp_f.sum);
         end
`ifndef FRAME_MON_CRC_EN
         checks++;
         if (f.sum !== 32'(HA * VA) * 32'h010203) begin
            errors++; $display("FAIL std_sum_const: got %h want %h", f.sum, 32'(HA * VA) * 32'h010203);
         end
`endif
         checks++;
         if (f.lines !== 12'(VA)) begin
            errors++; $display("FAIL std_lines: got %0d want %0d", f.lines, VA);
         end
         checks++;
         if (f.count !== 16'd1) begin
            errors++; $display("FAIL std_count: got %0d want 1", f.count);
         end
         checks++;
         if (f.cyc !== exp_f.cyc) begin
            errors++; $display("FAIL std_done_latency: got cycle %0d want %0d", f.cyc, exp_f.cyc);
         end
      end
      checks++;
      if (err_geometry !== 1'b0) begin
         errors++; $display("FAIL std_err: got %b want 0", err_geometry);
      end
      bad = 0;
      if (obs_pix.size() != exp_pix.size()) bad++;
      else foreach (exp_pix[i]) if (obs_pix[i] !== exp_pix[i]) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL std_pix_stream: %0d bad, got %0d pixels want %0d",
                  bad, obs_pix.size(), exp_pix.size());
      end
   endtask

   task automatic test_random_frames();
      frm_t f;
      int   bad;
      for (int r = 0; r < 3; r++) begin
         flush();
         send_body(VA, -1, 0, 1);
         close_frame(1'b0, 24'h0);
         checks++;
         if (obs_frm.size() !== 1) begin
            errors++; $display("FAIL rnd%0d_done: got %0d frames want 1", r, obs_frm.size());
         end else begin
            f = obs_frm.pop_front();
            checks++;
            if ({f.sum, f.lines, f.count} !== {exp_f.sum, exp_f.lines, exp_f.count}) begin
               errors++;
               $display("FAIL rnd%0d_frame: got sum=%h lines=%0d count=%0d want sum=%h lines=%0d count=%0d",
                        r, f.sum, f.lines, f.count, exp_f.sum, exp_f.lines, exp_f.count);
            end
         end
         checks++;
         if (err_geometry !== exp_err) begin
            errors++; $display("FAIL rnd%0d_err: got %b want %b", r, err_geometry, exp_err);
         end
         bad = 0;
         if (obs_pix.size() != exp_pix.size()) bad++;
         else foreach (exp_pix[i]) if (obs_pix[i] !== exp_pix[i]) bad++;
         checks++;
         if (bad !== 0) begin
            errors++; $display("FAIL rnd%0d_pix_stream: %0d bad", r, bad);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      frm_t f;
      flush();
      send_body(VA / 2, -1, 0, 1);
      @(posedge clk); #5;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pix_valid, frame_done, err_geometry, frame_sum, frame_lines, frame_count, pix_x, pix_y} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: sum=%h lines=%0d count=%0d err=%b want all 0",
                  frame_sum, frame_lines, frame_count, err_geometry);
      end
      model_clear();
      #27 rst_n = 1'b1;
      send_body(VA / 2, -1, 0, 1);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 0) begin
         errors++; $display("FAIL midreset_no_done: got %0d frames want 0", obs_frm.size());
      end
      flush();
      send_body(VA, -1, 0, 1);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 1) begin
         errors++; $display("FAIL midreset_done: got %0d frames want 1", obs_frm.size());
      end else begin
         f = obs_frm.pop_front();
         checks++;
         if ({f.sum, f.lines, f.count} !== {exp_f.sum, 12'(VA), 16'd1}) begin
            errors++;
            $display("FAIL midreset_frame: got sum=%h lines=%0d count=%0d want sum=%h lines=%0d count=1",
                     f.sum, f.lines, f.count, exp_f.sum, VA);
         end
      end
      checks++;
      if (err_geometry !== 1'b0) begin
         errors++; $display("FAIL midreset_err: got %b want 0", err_geometry);
      end
   endtask

   task automatic test_missing_line();
      frm_t f;
      flush();
      send_body(VA - 1, -1, 0, 1);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 1) begin
         errors++; $display("FAIL missing_done: got %0d frames want 1", obs_frm.size());
      end else begin
         f = obs_frm.pop_front();
         checks++;
         if (f.lines !== 12'(VA - 1)) begin
            errors++; $display("FAIL missing_lines: got %0d want %0d", f.lines, VA - 1);
         end
      end
      checks++;
      if (err_geometry !== 1'b1) begin
         errors++; $display("FAIL missing_err: got %b want 1", err_geometry);
      end
   endtask

   task automatic test_short_line();
      frm_t f;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      model_clear();
      flush();
      close_frame(1'b0, 24'h0);
      send_body(5, -1, 0, 1);
      checks++;
      if (err_geometry !== 1'b0) begin
         errors++; $display("FAIL short_err_before: got %b want 0", err_geometry);
      end
      send_body(1, 0, HA - 1, 1);
      checks++;
      if (err_geometry !== 1'b1) begin
         errors++; $display("FAIL short_err_at_line_end: got %b want 1", err_geometry);
      end
      send_body(VA - 6, -1, 0, 1);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 1) begin
         errors++; $display("FAIL short_done: got %0d frames want 1", obs_frm.size());
      end else begin
         f = obs_frm.pop_front();
         checks++;
         if ({f.lines, f.sum} !== {12'(VA), exp_f.sum}) begin
            errors++;
            $display("FAIL short_frame: got lines=%0d sum=%h want lines=%0d sum=%h",
                     f.lines, f.sum, VA, exp_f.sum);
         end
      end
      send_body(VA, -1, 0, 1);
      close_frame(1'b0, 24'h0);
      checks++;
      if ({err_geometry, frame_count} !== {1'b1, exp_count}) begin
         errors++;
         $display("FAIL short_sticky: got err=%b count=%0d want err=1 count=%0d",
                  err_geometry, frame_count, exp_count);
      end
   endtask

   task automatic test_coincident_pixel();
      frm_t        f;
      int          bad;
      logic [23:0] last_rgb;
      flush();
      last_rgb = 24'($urandom) | 24'h000001;
      send_body(VA, -1, 0, 1);
      close_frame(1'b1, last_rgb);
      checks++;
      if (obs_frm.size() !== 1) begin
         errors++; $display("FAIL coin_done: got %0d frames want 1", obs_frm.size());
      end else begin
         f = obs_frm.pop_front();
         checks++;
         if ({f.sum, f.lines, f.count} !== {exp_f.sum, exp_f.lines, exp_f.count}) begin
            errors++;
            $display("FAIL coin_frame: got sum=%h lines=%0d count=%0d want sum=%h lines=%0d count=%0d",
                     f.sum, f.lines, f.count, exp_f.sum, exp_f.lines, exp_f.count);
         end
      end
      bad = 0;
      if (obs_pix.size() != exp_pix.size()) bad++;
      else foreach (exp_pix[i]) if (obs_pix[i] !== exp_pix[i]) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL coin_pix_stream: %0d bad, got %0d pixels want %0d",
                  bad, obs_pix.size(), exp_pix.size());
      end
   endtask

   task automatic test_single_zero_pixel();
      frm_t f;
      flush();
      fixed_rgb = 24'h000000;
      send_body(1, 0, 1, 0);
      close_frame(1'b0, 24'h0);
      checks++;
      if (obs_frm.size() !== 1) begin
         errors++; $display("FAIL zero_done: got %0d frames want 1", obs_frm.size());
      end else begin
         f = obs_frm.pop_front();
         checks++;
         if ({f.sum, f.lines} !== {model_step(M_INIT, 24'h0), 12'd1}) begin
            errors++;
            $display("FAIL zero_frame: got sum=%h lines=%0d want sum=%h lines=1",
                     f.sum, f.lines, model_step(M_INIT, 24'h0));
         end
      end
   endtask

   initial begin
      vga.VGA_CLK = 1'b0;
      set_pins(1'b0, 1'b1, 1'b1, 24'h0);
      model_clear();
      fixed_rgb = 24'h010203;
      test_reset();
      test_standard_frame();
      test_random_frames();
      test_reset_mid_frame();
      test_missing_line();
      test_short_line();
      test_coincident_pixel();
      test_single_zero_pixel();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
